// File: rtl/irrigation_valve_sequencer.sv
// Irrigation valve sequencer: turns a level irrigation request into a timed
// valve-open / settle / pump / drain / cooldown sequence with min/max pump
// run limits so a flickering request cannot chatter the pump.
// Optional feature macro: IRRIGATION_RUN_COUNT_EN adds a saturating
// 8-bit run_count output that counts completed pump runs.
module irrigation_valve_sequencer #(
    parameter int CNT_W           = 8,
    parameter int SETTLE_CYCLES   = 2,
    parameter int MIN_RUN_CYCLES  = 4,
    parameter int MAX_RUN_CYCLES  = 10,
    parameter int DRAIN_CYCLES    = 3,
    parameter int COOLDOWN_CYCLES = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       irrigation,
    input  logic       sprinkler_select,
    output logic       dripper_valve,
    output logic       sprinkler_valve,
    output logic       pump,
    output logic       busy,
    output logic       timed_out,
    output logic [2:0] state
`ifdef IRRIGATION_RUN_COUNT_EN
    ,
    output logic [7:0] run_count
`endif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        RUN      = 3'd2,
        DRAIN    = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    // A phase of N cycles ends on the edge where the timer reads N-1.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOLDOWN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             mode_q, mode_d;
    logic             tmo_q, tmo_d;

    // State, phase timer, latched valve mode and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            mode_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mode_q  <= mode_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic; the timer restarts from zero on every state entry.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (irrigation) begin
                    state_d = SETTLE;
                    mode_d  = sprinkler_select;
                    tmo_d   = 1'b0;
                end
            end
            SETTLE: begin
                // Losing the request aborts before the pump ever starts.
                if (!irrigation)                state_d = DRAIN;
                else if (timer_q == SETTLE_LAST) state_d = RUN;
            end
            RUN: begin
                if (timer_q == MAX_LAST) begin
                    state_d = DRAIN;
                    tmo_d   = 1'b1;
                end else if (!irrigation && timer_q >= MIN_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (timer_q == DRAIN_LAST) state_d = COOLDOWN;
            end
            COOLDOWN: begin
                if (timer_q == COOL_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        timer_d = (state_d != state_q || state_q == IDLE) ? '0 : timer_q + 1'b1;
    end

    // Moore decode from registered state and latched mode only.
    always_comb begin
        dripper_valve   = 1'b0;
        sprinkler_valve = 1'b0;
        pump            = 1'b0;
        case (state_q)
            SETTLE, DRAIN: begin
                dripper_valve   = ~mode_q;
                sprinkler_valve = mode_q;
            end
            RUN: begin
                dripper_valve   = ~mode_q;
                sprinkler_valve = mode_q;
                pump            = 1'b1;
            end
            default: ;
        endcase
        busy      = (state_q != IDLE);
        timed_out = tmo_q;
        state     = state_q;
    end

`ifdef IRRIGATION_RUN_COUNT_EN
    logic [7:0] run_cnt_q;
    logic       run_end;

    assign run_end   = (state_q == RUN) && (state_d == DRAIN);
    assign run_count = run_cnt_q;

    // Saturating count of RUN->DRAIN transitions.
    always_ff @(posedge clock) begin
        if (reset)                           run_cnt_q <= 8'd0;
        else if (run_end && run_cnt_q != 8'hFF) run_cnt_q <= run_cnt_q + 8'd1;
    end
`endif

endmodule

// File: tb/tb_irrigation_valve_sequencer.sv
// Scoreboard bench for irrigation_valve_sequencer: a phase/countdown model
// predicts every cycle's outputs, a monitor compares them after each edge.
module tb_irrigation_valve_sequencer;

    localparam int SETTLE = 2, MINR = 4, MAXR = 10, DRAIN = 3, COOL = 5;

    logic       clock = 1'b0;
    logic       reset, irrigation, sprinkler_select;
    logic       dripper_valve, sprinkler_valve, pump, busy, timed_out;
    logic [2:0] state;
    logic [7:0] rc_act;

`ifdef IRRIGATION_RUN_COUNT_EN
    logic [7:0] run_count;
    assign rc_act = run_count;
`else
    assign rc_act = 8'd0;
`endif

    irrigation_valve_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .irrigation       (irrigation),
        .sprinkler_select (sprinkler_select),
        .dripper_valve    (dripper_valve),
        .sprinkler_valve  (sprinkler_valve),
        .pump             (pump),
        .busy             (busy),
        .timed_out        (timed_out),
        .state            (state)
`ifdef IRRIGATION_RUN_COUNT_EN
        ,
        .run_count        (run_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    // Reference model: phase name plus cycles remaining / pump cycles run.
    int phase = 0;    // 0 idle, 1 settle, 2 run, 3 drain, 4 cooldown
    int left  = 0;
    int ran   = 0;
    bit mode  = 0;
    bit tmo   = 0;
    int runs  = 0;

    task automatic model_step(input bit r, input bit irr, input bit sel);
        logic [15:0] e;
        bit valve_open;
        if (r) begin
            phase = 0; mode = 0; tmo = 0; runs = 0;
        end else begin
            case (phase)
                0: if (irr) begin phase = 1; left = SETTLE; mode = sel; tmo = 0; end
                1: begin
                    if (!irr) begin phase = 3; left = DRAIN; end
                    else begin
                        left--;
                        if (left == 0) begin phase = 2; ran = 0; end
                    end
                end
                2: begin
                    ran++;
                    if (ran == MAXR) begin
                        phase = 3; left = DRAIN; tmo = 1; runs++;
                    end else if (!irr && ran >= MINR) begin
                        phase = 3; left = DRAIN; runs++;
                    end
                end
                3: begin left--; if (left == 0) begin phase = 4; left = COOL; end end
                default: begin left--; if (left == 0) phase = 0; end
            endcase
        end
        valve_open = (phase >= 1 && phase <= 3);
`ifdef IRRIGATION_RUN_COUNT_EN
        e[7:0] = (runs > 255) ? 8'd255 : 8'(runs);
`else
        e[7:0] = 8'd0;
`endif
        e[15:13] = 3'(phase);
        e[12]    = valve_open && !mode;
        e[11]    = valve_open && mode;
        e[10]    = (phase == 2);
        e[9]     = (phase != 0);
        e[8]     = tmo;
        exp_q.push_back(e);
    endtask

    // Monitor: one packed comparison per cycle, sampled 1 time unit after the edge.
    initial begin
        logic [15:0] e, a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state, dripper_valve, sprinkler_valve, pump, busy, timed_out, rc_act};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got st=%0d drip=%b spr=%b pump=%b busy=%b tmo=%b rc=%0d expected st=%0d drip=%b spr=%b pump=%b busy=%b tmo=%b rc=%0d",
                             $time, a[15:13], a[12], a[11], a[10], a[9], a[8], a[7:0],
                             e[15:13], e[12], e[11], e[10], e[9], e[8], e[7:0]);
                end
            end
        end
    end

    // Drive inputs on the falling edge, predicting the state after the next rising edge.
    task automatic drive(input bit r, input bit irr, input bit sel);
        @(negedge clock);
        reset = r; irrigation = irr; sprinkler_select = sel;
        model_step(r, irr, sel);
    endtask

    initial begin
        int kind, seg_left;
        bit irr;
        reset = 1'b1; irrigation = 1'b0; sprinkler_select = 1'b0;
        drive(1, 0, 0);
        drive(1, 0, 0);
        // Directed opening: held request, dripper, runs into the max-run timeout.
        repeat (30) drive(0, 1, 0);
        // Sprinkler start, drop after one RUN cycle, toggle select afterwards.
        drive(1, 0, 0);
        drive(0, 1, 1);
        repeat (3) drive(0, 1, 1);
        repeat (20) drive(0, 0, $urandom_range(0, 1));
        // Single-cycle pulse then idle.
        drive(0, 1, 0);
        repeat (12) drive(0, 0, 0);
        // Randomized segments with occasional resets.
        kind = 0; seg_left = 0; irr = 0;
        repeat (4000) begin
            if (seg_left == 0) begin
                kind     = $urandom_range(0, 4);
                seg_left = $urandom_range(1, 25);
            end
            seg_left--;
            case (kind)
                0: irr = 1;
                1: irr = 0;
                2: irr = ~irr;
                3: irr = $urandom_range(0, 1);
                default: irr = (seg_left == 0);
            endcase
            drive(($urandom_range(0, 149) == 0), irr, $urandom_range(0, 1));
        end
        // Long held request: several hundred back-to-back runs saturate the counter.
        drive(1, 0, 0);
        repeat (6000) drive(0, 1, $urandom_range(0, 1));
        repeat (3) drive(0, 0, 0);
        @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
